// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq block: op encodings, control-word bit
// positions and the sequencer state type.
// Optional feature macro: ALU_SEQ_MUL_EN (adds the MUL state when defined).
package alu_pkg;

  localparam int unsigned OpW  = 2;
  localparam int unsigned CtlW = 6;

  // Op encoding; 2'b10 and 2'b11 are reserved and decode as LOGIC.
  localparam logic [OpW-1:0] OpLogic = 2'b00;
  localparam logic [OpW-1:0] OpMul   = 2'b01;

  // Control word {zx, nx, zy, ny, f, no}, zx in the MSB.
  localparam int unsigned CtlZx = 5;
  localparam int unsigned CtlNx = 4;
  localparam int unsigned CtlZy = 3;
  localparam int unsigned CtlNy = 2;
  localparam int unsigned CtlF  = 1;
  localparam int unsigned CtlNo = 0;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDone = 2'b10
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StDone = 2'b10
  } state_e;
`endif

endpackage

// File: rtl/alu_seq_if.sv
// Command/result handshake bundle for alu_seq.
//   master: drives in_valid, op, ctl, x, y, out_ready
//   slave : drives in_ready, out_valid, out, zr, ng, cout
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [OpW-1:0]   op;
  logic [CtlW-1:0]  ctl;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             cout;

  modport master (
    output in_valid, op, ctl, x, y, out_ready,
    input  in_ready, out_valid, out, zr, ng, cout
  );

  modport slave (
    input  in_valid, op, ctl, x, y, out_ready,
    output in_ready, out_valid, out, zr, ng, cout
  );

endinterface

// File: rtl/alu_core.sv
// Combinational Hack-style ALU datapath.
//   x_i, y_i         operands
//   ctl_i            control word {zx,nx,zy,ny,f,no}
//   mul_sel_i        1: take mul_lo_i as the pre-negation result
//   mul_lo_i         low half of a product from the sequencer
//   mul_hi_nz_i      upper half of that product is nonzero
//   x_pre_o, y_pre_o preprocessed operands (zero/negate applied)
//   res_o            final result after optional inversion
//   zr_o, ng_o       res_o == 0, res_o MSB
//   cout_o           add carry (f=1), product overflow (mul), else 0
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [CtlW-1:0]  ctl_i,
  input  logic             mul_sel_i,
  input  logic [WIDTH-1:0] mul_lo_i,
  input  logic             mul_hi_nz_i,
  output logic [WIDTH-1:0] x_pre_o,
  output logic [WIDTH-1:0] y_pre_o,
  output logic [WIDTH-1:0] res_o,
  output logic             zr_o,
  output logic             ng_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] x_z;
  logic [WIDTH-1:0] y_z;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;

  always_comb begin
    x_z     = ctl_i[CtlZx] ? '0 : x_i;
    x_pre_o = ctl_i[CtlNx] ? ~x_z : x_z;
    y_z     = ctl_i[CtlZy] ? '0 : y_i;
    y_pre_o = ctl_i[CtlNy] ? ~y_z : y_z;

    sum = {1'b0, x_pre_o} + {1'b0, y_pre_o};

    if (mul_sel_i) begin
      r = mul_lo_i;
    end else if (ctl_i[CtlF]) begin
      r = sum[WIDTH-1:0];
    end else begin
      r = x_pre_o & y_pre_o;
    end

    res_o  = ctl_i[CtlNo] ? ~r : r;
    zr_o   = (res_o == '0);
    ng_o   = res_o[WIDTH-1];
    cout_o = mul_sel_i ? mul_hi_nz_i : (ctl_i[CtlF] & sum[WIDTH]);
  end

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU: accepts one command at a time, computes a Hack-style LOGIC
// result in one cycle or (with ALU_SEQ_MUL_EN) an unsigned shift-add MUL over
// WIDTH cycles, then holds the result until the consumer takes it.
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   alu_seq_if slave: command in, result/flags out
// Macro ALU_SEQ_MUL_EN: when undefined there is no MUL state or multiplier
// storage and op 01 executes as LOGIC.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             cout_q, cout_d;
  logic             load_res;

  logic [CtlW-1:0]  core_ctl;
  logic             mul_sel;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi_nz;
  logic [WIDTH-1:0] x_pre;
  logic [WIDTH-1:0] y_pre;
  logic [WIDTH-1:0] res;
  logic             res_zr;
  logic             res_ng;
  logic             res_cout;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x_i        (bus.x),
    .y_i        (bus.y),
    .ctl_i      (core_ctl),
    .mul_sel_i  (mul_sel),
    .mul_lo_i   (mul_lo),
    .mul_hi_nz_i(mul_hi_nz),
    .x_pre_o    (x_pre),
    .y_pre_o    (y_pre),
    .res_o      (res),
    .zr_o       (res_zr),
    .ng_o       (res_ng),
    .cout_o     (res_cout)
  );

  // in_ready is gated by rst_n so it reads 0 while reset is asserted.
  assign bus.in_ready  = (state_q == StIdle) & rst_n;
  assign bus.out_valid = (state_q == StDone);
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.cout      = cout_q;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [CtlW-1:0]    ctl_q, ctl_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mul_sum;

  // While multiplying, the captured ctl drives the core so only 'no' and the
  // flag logic act on the product; x/y on the bus are ignored.
  assign mul_sel   = (state_q == StMul);
  assign core_ctl  = mul_sel ? ctl_q : bus.ctl;
  assign mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_lo    = mul_sum[WIDTH-1:0];
  assign mul_hi_nz = |mul_sum[2*WIDTH-1:WIDTH];
`else
  logic unused_sig;

  assign mul_sel    = 1'b0;
  assign core_ctl   = bus.ctl;
  assign mul_lo     = '0;
  assign mul_hi_nz  = 1'b0;
  assign unused_sig = ^{bus.op, x_pre, y_pre};
`endif

  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    ctl_d    = ctl_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          if (bus.op == OpMul) begin
            state_d  = StMul;
            ctl_d    = bus.ctl;
            mcand_d  = {{WIDTH{1'b0}}, x_pre};
            mplier_d = y_pre;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = StDone;
            load_res = 1'b1;
          end
`else
          state_d  = StDone;
          load_res = 1'b1;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      // One multiplier bit per cycle; the last step loads the finished result.
      StMul: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          load_res = 1'b1;
        end
      end
`endif
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    zr_d   = zr_q;
    ng_d   = ng_q;
    cout_d = cout_q;
    if (load_res) begin
      out_d  = res;
      zr_d   = res_zr;
      ng_d   = res_ng;
      cout_d = res_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      out_q   <= '0;
      zr_q    <= 1'b1;
      ng_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      cout_q  <= cout_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      ctl_q    <= ctl_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH = 16). Expected results come from a
// plain-arithmetic reference model or literal values and are queued on accept;
// a monitor compares whenever out_valid is high and pops on handshake.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 16;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif
  localparam int MulLat = W + 1;

  typedef struct {
    logic [W-1:0] out;
    logic         zr;
    logic         ng;
    logic         cout;
    int           lat;
    int           acc_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   seen_first = 1'b0;
  int   rdy_mode = 0;  // 0 random, 1 held low, 2 held high

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] o, input logic z, input logic n,
                              input logic c, input int lat);
    exp_t e;
    e.out = o; e.zr = z; e.ng = n; e.cout = c; e.lat = lat; e.acc_cyc = 0;
    return e;
  endfunction

  // Reference: operate on integers, then reduce modulo 2^W.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] ctl,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned xp, yp, full, m;
    logic [W-1:0]    r;
    exp_t            e;
    m  = 64'd1 << W;
    xp = ctl[CtlZx] ? 64'd0 : 64'(x);
    if (ctl[CtlNx]) xp = (m - 1) - xp;
    yp = ctl[CtlZy] ? 64'd0 : 64'(y);
    if (ctl[CtlNy]) yp = (m - 1) - yp;
    e.lat  = 1;
    e.cout = 1'b0;
    if (MulEn && op == OpMul) begin
      full   = xp * yp;
      e.cout = (full >= m);
      e.lat  = MulLat;
    end else if (ctl[CtlF]) begin
      full   = xp + yp;
      e.cout = (full >= m);
    end else begin
      full = xp & yp;
    end
    r = W'(full % m);
    if (ctl[CtlNo]) r = ~r;
    e.out     = r;
    e.zr      = (r == '0);
    e.ng      = r[W-1];
    e.acc_cyc = 0;
    return e;
  endfunction

  // Starts just after a rising edge; the accept edge follows the negedge
  // where in_ready is seen high with in_valid asserted.
  task automatic send(input logic [1:0] op, input logic [5:0] ctl,
                      input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    int budget;
    bit ok;
    @(posedge clk); #1;
    bus.op = op; bus.ctl = ctl; bus.x = x; bus.y = y; bus.in_valid = 1'b1;
    budget = 300;
    ok = 1'b0;
    while (!ok && budget > 0) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
      else budget--;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      bus.in_valid = 1'b0;
      return;
    end
    e.acc_cyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    // Scramble inputs after accept: the captured command must not change.
    bus.in_valid = 1'b0;
    bus.op  = 2'($urandom);
    bus.ctl = 6'($urandom);
    bus.x   = W'($urandom);
    bus.y   = W'($urandom);
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       bus.out_ready = 1'b0;
        2:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: out=%0h with no command outstanding", bus.out);
      end else begin
        chk("out", 64'(bus.out), 64'(sb[0].out));
        chk("zr", 64'(bus.zr), 64'(sb[0].zr));
        chk("ng", 64'(bus.ng), 64'(sb[0].ng));
        chk("cout", 64'(bus.cout), 64'(sb[0].cout));
        if (!seen_first) begin
          chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
          seen_first = 1'b1;
        end
        if (bus.out_ready === 1'b1) begin
          void'(sb.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [1:0]   r_op;
    logic [5:0]   r_ctl;
    logic [W-1:0] r_x, r_y, held;
    int           budget;

    bus.in_valid = 1'b0;
    bus.op  = '0;
    bus.ctl = '0;
    bus.x   = '0;
    bus.y   = '0;

    // Reset values while asserted, before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out", 64'(bus.out), 64'h0);
    chk("rst_zr", 64'(bus.zr), 64'h1);
    chk("rst_ng", 64'(bus.ng), 64'h0);
    chk("rst_cout", 64'(bus.cout), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'h1);

    // Directed vectors.
    send(OpLogic, 6'b010011, 16'h0005, 16'h0003, mk(16'h0002, 1'b0, 1'b0, 1'b0, 1));
    send(OpLogic, 6'b000010, 16'hFFFF, 16'h0001, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1));
    send(OpLogic, 6'b000010, 16'h7FFF, 16'h0001, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1));
    send(2'b11,   6'b000010, 16'h0010, 16'h0020, mk(16'h0030, 1'b0, 1'b0, 1'b0, 1));
`ifdef ALU_SEQ_MUL_EN
    send(OpMul, 6'b000010, 16'h0002, 16'h0003, mk(16'h0006, 1'b0, 1'b0, 1'b0, MulLat));
    send(OpMul, 6'b000010, 16'h0012, 16'h0034, mk(16'h03A8, 1'b0, 1'b0, 1'b0, MulLat));
    send(OpMul, 6'b000010, 16'h0100, 16'h0100, mk(16'h0000, 1'b1, 1'b0, 1'b1, MulLat));
    send(OpMul, 6'b000011, 16'h0003, 16'h0004, mk(16'hFFF3, 1'b0, 1'b1, 1'b0, MulLat));
`else
    send(OpMul, 6'b000010, 16'h0002, 16'h0003, mk(16'h0005, 1'b0, 1'b0, 1'b0, 1));
`endif

    // Backpressure: result held with out_ready low, new commands ignored.
    rdy_mode = 1;
    send(OpLogic, 6'b000010, 16'h1234, 16'h0101, mk(16'h1335, 1'b0, 1'b0, 1'b0, 1));
    budget = 50;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("bp_valid_seen", 64'(bus.out_valid), 64'h1);
    held = bus.out;
    bus.in_valid = 1'b1; bus.op = OpLogic; bus.ctl = 6'b000010; bus.x = 16'h0001; bus.y = 16'h0001;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
      chk("bp_out_stable", 64'(bus.out), 64'(held));
      chk("bp_out_valid", 64'(bus.out_valid), 64'h1);
    end
    bus.in_valid = 1'b0;
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'h0);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'h1);
    rdy_mode = 0;

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_ctl = 6'($urandom);
      case ($urandom_range(0, 3))
        0:       r_x = '1;
        1:       r_x = '0;
        default: r_x = W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       r_y = '1;
        1:       r_y = 16'h0001;
        default: r_y = W'($urandom);
      endcase
      send(r_op, r_ctl, r_x, r_y, model(r_op, r_ctl, r_x, r_y));
    end

    // Reset mid-operation (mid-MUL, or in DONE when MUL is not built).
    rdy_mode = 1;
    send(OpMul, 6'b000010, 16'h00FF, 16'h0003, model(OpMul, 6'b000010, 16'h00FF, 16'h0003));
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 64'(bus.out), 64'h0);
    chk("mid_rst_zr", 64'(bus.zr), 64'h1);
    chk("mid_rst_ng", 64'(bus.ng), 64'h0);
    chk("mid_rst_cout", 64'(bus.cout), 64'h0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'h0);
    sb.delete();
    seen_first = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    chk("mid_rst_release_in_ready", 64'(bus.in_ready), 64'h1);
    send(OpLogic, 6'b010011, 16'd100, 16'd58, mk(16'd42, 1'b0, 1'b0, 1'b0, 1));
    send(OpLogic, 6'b000000, 16'hF0F0, 16'h3C3C, mk(16'h3030, 1'b0, 1'b0, 1'b0, 1));

    // Drain outstanding results.
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_outstanding", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
